// File: rtl/prog_sequencer.sv
// Run controller: steps the core through a fixed list of programs, holding init
// while presenting each start PC, then timing each run until halt or the watchdog fires.
module prog_sequencer #(
   parameter int          NUM_PROG    = 3,
   parameter logic [9:0]  PROG0_ADDR  = 10'd0,
   parameter logic [9:0]  PROG1_ADDR  = 10'd219,
   parameter logic [9:0]  PROG2_ADDR  = 10'd686,
   parameter logic [9:0]  PROG3_ADDR  = 10'd0,
   parameter int          INIT_CYCLES = 2,
   parameter logic [15:0] MAX_CYCLES  = 16'hFFFF
) (
   input  logic        CLK,
   input  logic        init,
   input  logic        start,
   input  logic        halt,
   output logic        core_init,
   output logic [9:0]  start_addr,
   output logic [1:0]  prog_id,
   output logic        busy,
   output logic        done,
   output logic [15:0] run_cycles,
   output logic        run_valid,
   output logic        timeout
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [7:0] LOAD_LAST = 8'(INIT_CYCLES - 1);
   localparam logic [1:0] LAST_PROG = 2'(NUM_PROG - 1);

   state_t      state, state_nxt;
   logic [7:0]  load_cnt;
   logic [15:0] cyc_cnt;
   logic        wdog, prog_end;

   // Halt and watchdog landing together are a single end event.
   assign wdog     = (state == RUN) && (cyc_cnt == MAX_CYCLES);
   assign prog_end = (state == RUN) && (halt || wdog);

   always_ff @(posedge CLK or posedge init) begin
      if (init) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      core_init = (state != RUN);
      busy      = (state == LOAD) || (state == RUN);
      done      = (state == DONE);
      case (state)
         IDLE, DONE: if (start) state_nxt = LOAD;
         LOAD:       if (load_cnt == LOAD_LAST) state_nxt = RUN;
         RUN:        if (prog_end) state_nxt = (prog_id == LAST_PROG) ? DONE : LOAD;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start_addr = PROG0_ADDR;
      case (prog_id)
         2'd0: start_addr = PROG0_ADDR;
         2'd1: start_addr = PROG1_ADDR;
         2'd2: start_addr = PROG2_ADDR;
         2'd3: start_addr = PROG3_ADDR;
         default: start_addr = PROG0_ADDR;
      endcase
   end

   always_ff @(posedge CLK or posedge init) begin
      if (init) begin
         prog_id    <= 2'd0;
         load_cnt   <= 8'd0;
         cyc_cnt    <= 16'd0;
         run_cycles <= 16'd0;
         run_valid  <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         run_valid <= 1'b0;
         case (state)
            IDLE, DONE: if (start) begin
               prog_id  <= 2'd0;
               load_cnt <= 8'd0;
               timeout  <= 1'b0;
            end
            LOAD: begin
               load_cnt <= load_cnt + 8'd1;
               cyc_cnt  <= 16'd0;
            end
            RUN: if (prog_end) begin
               // counter+1 would wrap when the limit is all ones
               run_cycles <= wdog ? MAX_CYCLES : cyc_cnt + 16'd1;
               run_valid  <= 1'b1;
               load_cnt   <= 8'd0;
               if (wdog) timeout <= 1'b1;
               if (prog_id != LAST_PROG) prog_id <= prog_id + 2'd1;
            end else begin
               cyc_cnt <= cyc_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a scoreboard checks every run_valid pulse against the
// expected run result; directed checks cover reset, LOAD timing, async init and NUM_PROG=1.
module tb_prog_sequencer;

   typedef struct packed {
      logic [15:0] cyc;
      logic        to;
      logic [1:0]  pid;
      logic [9:0]  addr;
      logic        dn;
   } exp_t;

   logic CLK = 1'b0;
   logic init, start, halt, start1, halt1;
   logic core_init, busy, done, run_valid, timeout;
   logic [9:0] start_addr;
   logic [1:0] prog_id;
   logic [15:0] run_cycles;
   logic core_init1, busy1, done1, run_valid1, timeout1;
   logic [9:0] start_addr1;
   logic [1:0] prog_id1;
   logic [15:0] run_cycles1;

   int npass = 0, ntot = 0;
   exp_t q[$];

   always #5 CLK = ~CLK;

   prog_sequencer #(.MAX_CYCLES(16'd50)) dut (
      .CLK(CLK), .init(init), .start(start), .halt(halt),
      .core_init(core_init), .start_addr(start_addr), .prog_id(prog_id),
      .busy(busy), .done(done), .run_cycles(run_cycles),
      .run_valid(run_valid), .timeout(timeout));

   prog_sequencer #(.NUM_PROG(1)) dut1 (
      .CLK(CLK), .init(init), .start(start1), .halt(halt1),
      .core_init(core_init1), .start_addr(start_addr1), .prog_id(prog_id1),
      .busy(busy1), .done(done1), .run_cycles(run_cycles1),
      .run_valid(run_valid1), .timeout(timeout1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic wait_ci(input logic v, input int lim, input string name, output int k);
      k = 0;
      while (core_init !== v && k < lim) begin tick(); k++; end
      chk(name, core_init, v);
   endtask

   task automatic run_halt(input int n);
      repeat (n - 1) tick();
      halt = 1'b1; tick(); halt = 1'b0;
   endtask

   // Monitor: every run_valid pulse must match the oldest expected result.
   always @(negedge CLK) begin
      if (run_valid) begin
         if (q.size() == 0) chk("spurious run_valid", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("run_cycles", run_cycles, e.cyc);
            chk("timeout", timeout, e.to);
            chk("prog_id", prog_id, e.pid);
            chk("start_addr", start_addr, e.addr);
            chk("done", done, e.dn);
            chk("core_init after end", core_init, 1);
         end
      end
   end

   initial begin
      int k;
      init = 1'b1; start = 1'b0; halt = 1'b0; start1 = 1'b0; halt1 = 1'b0;
      tick(); tick();
      chk("rst core_init", core_init, 1);
      chk("rst start_addr", start_addr, 0);
      chk("rst prog_id", prog_id, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst run_cycles", run_cycles, 0);
      chk("rst run_valid", run_valid, 0);
      chk("rst timeout", timeout, 0);
      init = 1'b0; tick();
      chk("idle holds", busy, 0);

      // start pulse: two LOAD cycles at address 0, then RUN
      start = 1'b1; tick(); start = 1'b0;
      chk("load0 core_init", core_init, 1);
      chk("load0 addr", start_addr, 0);
      chk("load0 busy", busy, 1);
      tick(); chk("load1 core_init", core_init, 1);
      tick(); chk("run core_init", core_init, 0);

      q.push_back('{cyc: 16'd10, to: 1'b0, pid: 2'd1, addr: 10'd219, dn: 1'b0});
      run_halt(10);
      wait_ci(0, 10, "run p1", k);
      chk("gap cycles", k, 2);
      q.push_back('{cyc: 16'd20, to: 1'b0, pid: 2'd2, addr: 10'd686, dn: 1'b0});
      run_halt(20);
      wait_ci(0, 10, "run p2", k);
      q.push_back('{cyc: 16'd30, to: 1'b0, pid: 2'd2, addr: 10'd686, dn: 1'b1});
      run_halt(30);
      tick();
      chk("done", done, 1);
      chk("done busy", busy, 0);
      chk("done prog_id", prog_id, 2);
      chk("done run_cycles", run_cycles, 30);

      // restart from DONE with start and halt held through LOAD
      start = 1'b1; halt = 1'b1; tick();
      chk("restart done", done, 0);
      chk("restart prog_id", prog_id, 0);
      chk("restart addr", start_addr, 0);
      chk("restart core_init", core_init, 1);
      tick(); chk("load hold core_init", core_init, 1);
      tick(); chk("load exact run", core_init, 0);
      start = 1'b0; halt = 1'b0;

      // watchdog: no halt on program 0
      q.push_back('{cyc: 16'd50, to: 1'b1, pid: 2'd1, addr: 10'd219, dn: 1'b0});
      wait_ci(1, 100, "watchdog end", k);
      wait_ci(0, 10, "run p1 after wd", k);
      chk("timeout sticky", timeout, 1);

      // async init mid-RUN of program 1
      repeat (3) tick();
      #3 init = 1'b1;
      #1;
      chk("async core_init", core_init, 1);
      chk("async prog_id", prog_id, 0);
      chk("async addr", start_addr, 0);
      chk("async busy", busy, 0);
      chk("async timeout", timeout, 0);
      @(posedge CLK); #1 init = 1'b0;
      tick(); tick();
      chk("post-init idle", core_init, 1);
      chk("post-init busy", busy, 0);

      start = 1'b1; tick(); start = 1'b0;
      wait_ci(0, 10, "rerun p0", k);
      q.push_back('{cyc: 16'd7, to: 1'b0, pid: 2'd1, addr: 10'd219, dn: 1'b0});
      run_halt(7);

      // NUM_PROG=1 instance ends after its single program
      start1 = 1'b1; tick(); start1 = 1'b0;
      tick(); tick();
      chk("np1 run", core_init1, 0);
      repeat (3) tick();
      halt1 = 1'b1; tick(); halt1 = 1'b0;
      chk("np1 run_valid", run_valid1, 1);
      chk("np1 run_cycles", run_cycles1, 4);
      chk("np1 done", done1, 1);
      chk("np1 busy", busy1, 0);
      chk("np1 prog_id", prog_id1, 0);

      repeat (2) tick();
      chk("scoreboard drained", q.size(), 0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Top-level run controller for the single-issue core. It sequences the fetch unit and the rest of the core through a fixed list of programs stored back to back in instruction memory. For each program it holds the core in `init` while presenting that program's start PC, then releases the core and waits for `halt`, counting execution cycles. After the last program it reports completion. It sits between the testbench/top-level `start` and the core's `init`/start-address inputs.

## Interface
- `NUM_PROG`, 3, number of programs in the sequence (1..4)
- `PROG0_ADDR`, 0, start PC of program 0
- `PROG1_ADDR`, 219, start PC of program 1
- `PROG2_ADDR`, 686, start PC of program 2
- `PROG3_ADDR`, 0, start PC of program 3 (used only if `NUM_PROG`=4)
- `INIT_CYCLES`, 2, cycles `core_init` is held per program (>=1)
- `MAX_CYCLES`, 16'hFFFF, watchdog limit on run cycles per program
- `CLK`  input  1  clock; all state changes on posedge
- `init`  input  1  asynchronous, active-high reset of this block
- `start`  input  1  request to begin the full sequence (level or pulse)
- `halt`  input  1  core has executed its halt instruction (from decode)
- `core_init`  output  1  drives the core's init; PC loads `start_addr`
- `start_addr`  output  10  start PC for the current program
- `prog_id`  output  2  index of the current/last program
- `busy`  output  1  high in LOAD and RUN
- `done`  output  1  high in DONE
- `run_cycles`  output  16  cycle count of the most recently finished program
- `run_valid`  output  1  one-cycle pulse when `run_cycles` updates
- `timeout`  output  1  sticky; set if any program hit `MAX_CYCLES`

## Operation
- States: IDLE, LOAD, RUN, DONE.
- Reset (`init`=1, async): state IDLE, `prog_id`=0, `core_init`=1, `start_addr`=`PROG0_ADDR`, `busy`=0, `done`=0, `run_cycles`=0, `run_valid`=0, `timeout`=0, internal counters 0.
- IDLE: `core_init`=1 (core held). `start`=1 -> LOAD, `prog_id`=0, load counter 0, `timeout` cleared.
- LOAD: `core_init`=1, `start_addr` = address for `prog_id`. Load counter counts 0..`INIT_CYCLES`-1. After the last count, go to RUN. `halt` and `start` are ignored.
- RUN: `core_init`=0. The cycle counter increments each RUN cycle and saturates at `MAX_CYCLES`.
- Program end in RUN: on `halt`=1, or when the counter reaches `MAX_CYCLES` (watchdog).
  - `run_cycles` <= counter+1, saturated at `MAX_CYCLES`.
  - `run_valid` pulses.
  - If the end was the watchdog, `timeout` <= 1.
  - If `prog_id`==`NUM_PROG`-1 -> DONE. Otherwise `prog_id`+1 -> LOAD.
- DONE: `done`=1, `core_init`=1. `prog_id` and `run_cycles` hold. `start`=1 -> LOAD with `prog_id`=0, as from IDLE.
- `start` is ignored in LOAD and RUN; no restart mid-sequence.
- `halt` and watchdog in the same cycle count as one end event. `timeout` is set because the counter hit the limit.
- Address mux: `prog_id` 0..3 -> PROG0..PROG3_ADDR. Any out-of-range index is impossible by construction.
- Width rules: the counter is 16-bit unsigned and never wraps. `start_addr` is 10-bit, matching the fetch PC.

## Timing
- Registered outputs are Moore outputs of state. The exception is `run_valid`, a registered pulse in the first cycle after the end event.
- `start` sampled high at edge E (IDLE): LOAD from E. `core_init`=1 and `start_addr` valid from E through E+`INIT_CYCLES`-1. RUN from edge E+`INIT_CYCLES`; `core_init`=0 after that edge.
- First RUN cycle counts as 1. If `halt` is sampled at the Nth RUN edge, `run_cycles`=N.
- `halt` sampled at edge H:
  - `core_init`=1 after H.
  - `start_addr` of the next program is valid after H.
  - `run_valid`=1 for the cycle after H only.
- Program-to-program gap: exactly `INIT_CYCLES` cycles with `core_init`=1.
- `init` asserted mid-RUN: outputs go to reset values immediately, with no clock needed. Sequencing resumes only on a new `start` after `init` deasserts.

## Test plan
- Reset then `start` pulse, defaults: `core_init` high for 2 cycles with `start_addr`=0, then low. `halt` after 10 RUN cycles -> `run_cycles`=10, `run_valid` one cycle, `start_addr`=219.
- Full sequence: halts after 10/20/30 cycles -> `start_addr` 0, 219, 686 in order. `run_cycles` 10, 20, 30. `done`=1, `prog_id`=2, `busy`=0.
- Watchdog with `MAX_CYCLES`=50 and no `halt` -> `run_cycles`=50, `timeout`=1, advance to program 1. `timeout` stays 1 until the next `start`.
- `halt` and `start` held high during LOAD -> no state change; RUN still begins after exactly `INIT_CYCLES`.
- Async `init` mid-RUN of program 1 -> `core_init`=1, `prog_id`=0, `start_addr`=0 before the next edge. State IDLE.
- In DONE, `start` -> restart at `prog_id`=0, `start_addr`=0, `done`=0. `NUM_PROG`=1 variant goes to DONE after the first `halt`.
